// File: rtl/filtro_temp_pkg.sv
// Shared types for the temperature filter and the downstream monitor stage.
package filtro_temp_pkg;

    localparam int N_VENTANA  = 4;
    localparam int ANCHO_TEMP = 11;
    localparam int ANCHO_SUMA = 13;

    typedef logic signed [ANCHO_TEMP-1:0] temp_t;
    typedef logic signed [ANCHO_SUMA-1:0] suma_t;

    typedef enum logic {
        LLENADO   = 1'b0,
        OPERACION = 1'b1
    } estado_filtro_t;

    // |a - b| computed at sum width so the full 11-bit span cannot wrap.
    function automatic suma_t abs_dif(input temp_t a, input temp_t b);
        suma_t d;
        d = suma_t'(a) - suma_t'(b);
        return (d < 0) ? -d : d;
    endfunction

endpackage

// File: rtl/filtro_temp_vigilante_sensor.sv
// Sensor watchdog: counts idle cycles since the last sample strobe and flags a
// sensor fault once TIMEOUT_CICLOS cycles pass without one.
module vigilante_sensor #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic clk,
    input  logic arst_n,
    input  logic muestra_valida,
    output logic sensor_falla
);

    localparam int                ANCHO  = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [ANCHO-1:0]  LIMITE = ANCHO'(TIMEOUT_CICLOS);

    logic [ANCHO-1:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (muestra_valida) begin
            cuenta_d = '0;
        end else if (cuenta_q != LIMITE) begin
            cuenta_d = cuenta_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign sensor_falla = (cuenta_q == LIMITE);

endmodule

// File: rtl/filtro_temp.sv
// 4-sample moving-average temperature filter with sensor watchdog.
// Define RECHAZO_PICOS_EN to enable spike rejection while in OPERACION.
module filtro_temp
    import filtro_temp_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int UMBRAL_PICO    = 50
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic signed [10:0] muestra,
    input  logic               muestra_valida,
    input  logic               limpiar,
    output logic signed [10:0] temp_filtrada,
    output logic               temp_valida,
    output logic               sensor_falla,
    output logic [7:0]         picos_rechazados
);

    localparam int                   ANCHO_PTR = $clog2(N_VENTANA);
    localparam logic [ANCHO_PTR-1:0] ULTIMO    = ANCHO_PTR'(N_VENTANA - 1);

    estado_filtro_t       estado_q, estado_d;
    temp_t                ventana_q [N_VENTANA];
    temp_t                ventana_d [N_VENTANA];
    logic [ANCHO_PTR-1:0] ptr_q, ptr_d;
    temp_t                temp_q, temp_d;
    logic                 valida_q, valida_d;

    logic  acepta;
    logic  publica;
    suma_t suma;
    temp_t media;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado_q <= LLENADO;
        end else begin
            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
            estado_q <= estado_d;
        end
    end

    // Next-state logic: the pointer doubles as the fill count while in LLENADO.
    always_comb begin
        estado_d = estado_q;
        if (limpiar) begin
            estado_d = LLENADO;
        end else if (acepta && ptr_q == ULTIMO) begin
            estado_d = OPERACION;
        end
    end

    // Output control: an accepted sample publishes once the window is full.
    always_comb begin
        publica = acepta && (estado_q == OPERACION || ptr_q == ULTIMO);
    end

`ifdef RECHAZO_PICOS_EN
    localparam logic [1:0] MAX_RECHAZOS = 2'd3;

    logic [1:0] consec_q, consec_d;
    logic [7:0] picos_q, picos_d;
    logic       fuera_umbral;
    logic       rechaza;

    assign fuera_umbral = abs_dif(muestra, temp_q) > suma_t'(UMBRAL_PICO);

    // A persistent step is accepted after three rejections, so the filter can follow it.
    always_comb begin
        acepta   = 1'b0;
        rechaza  = 1'b0;
        consec_d = consec_q;
        picos_d  = picos_q;
        if (muestra_valida && !limpiar) begin
            if (estado_q == OPERACION && fuera_umbral && consec_q != MAX_RECHAZOS) begin
                rechaza = 1'b1;
            end else begin
                acepta = 1'b1;
            end
        end
        if (limpiar || acepta) begin
            consec_d = '0;
        end else if (rechaza) begin
            consec_d = consec_q + 1'b1;
            if (picos_q != 8'hFF) begin
                picos_d = picos_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            consec_q <= '0;
            picos_q  <= '0;
        end else begin
            consec_q <= consec_d;
            picos_q  <= picos_d;
        end
    end

    assign picos_rechazados = picos_q;
`else
    assign acepta           = muestra_valida && !limpiar;
    assign picos_rechazados = '0;
`endif

    // Sum of the window as it will be after this sample replaces slot ptr_q.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        suma = '0;
        for (int i = 0; i < N_VENTANA; i++) begin
            suma += (ANCHO_PTR'(i) == ptr_q) ? suma_t'(muestra) : suma_t'(ventana_q[i]);
        end
    end

    assign media = temp_t'(suma >>> 2);

    always_comb begin
        ventana_d = ventana_q;
        ptr_d     = ptr_q;
        temp_d    = temp_q;
        valida_d  = publica;
        if (limpiar) begin
            for (int i = 0; i < N_VENTANA; i++) begin
                ventana_d[i] = '0;
            end
            ptr_d = '0;
        end else if (acepta) begin
            ventana_d[ptr_q] = muestra;
            ptr_d            = ptr_q + 1'b1;
        end
        if (publica) begin
            temp_d = media;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // NOTE: the window is a handful of flops, so it is reset rather than left undefined.
            for (int i = 0; i < N_VENTANA; i++) begin
                ventana_q[i] <= '0;
            end
            ptr_q    <= '0;
            temp_q   <= '0;
            valida_q <= 1'b0;
        end else begin
            ventana_q <= ventana_d;
            ptr_q     <= ptr_d;
            temp_q    <= temp_d;
            valida_q  <= valida_d;
        end
    end

    assign temp_filtrada = temp_q;
    assign temp_valida   = valida_q;

    vigilante_sensor #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_vigilante (
        .clk           (clk),
        .arst_n        (arst_n),
        .muestra_valida(muestra_valida),
        .sensor_falla  (sensor_falla)
    );

endmodule

// File: tb/tb_filtro_temp.sv
// Self-checking bench for filtro_temp: directed scenarios plus random traffic
// checked against a queue-based reference model of the filter and watchdog.
module tb_filtro_temp;

    localparam int TIMEOUT = 1000;
    localparam int UMBRAL  = 50;

    logic               clk = 1'b0;
    logic               arst_n = 1'b0;
    logic signed [10:0] muestra = '0;
    logic               muestra_valida = 1'b0;
    logic               limpiar = 1'b0;
    logic signed [10:0] temp_filtrada;
    logic               temp_valida;
    logic               sensor_falla;
    logic [7:0]         picos_rechazados;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int                 hist[$];
    int                 to_cnt;
    int                 consec;
    int                 exp_picos;
    logic signed [10:0] exp_temp;
    logic               exp_valida;
    logic               exp_falla;

    filtro_temp #(
        .TIMEOUT_CICLOS(TIMEOUT),
        .UMBRAL_PICO   (UMBRAL)
    ) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .muestra         (muestra),
        .muestra_valida  (muestra_valida),
        .limpiar         (limpiar),
        .temp_filtrada   (temp_filtrada),
        .temp_valida     (temp_valida),
        .sensor_falla    (sensor_falla),
        .picos_rechazados(picos_rechazados)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic int media_piso(input int s);
        int r;
        r = s % 4;
        if (r < 0) r += 4;
        return (s - r) / 4;
    endfunction

    task automatic modelo_reset();
        hist.delete();
        to_cnt     = 0;
        consec     = 0;
        exp_picos  = 0;
        exp_temp   = '0;
        exp_valida = 1'b0;
        exp_falla  = 1'b0;
    endtask

    // Drive one cycle of stimulus, step past the edge and advance the model.
    task automatic ciclo(input logic mv, input logic lim, input int m);
        bit aceptar;
        int s;
        muestra_valida = mv;
        limpiar        = lim;
        muestra        = 11'(m);
        @(posedge clk);
        #1;
        if (mv) to_cnt = 0;
        else if (to_cnt < TIMEOUT) to_cnt++;
        exp_falla  = (to_cnt == TIMEOUT);
        exp_valida = 1'b0;
        if (lim) begin
            hist.delete();
            consec = 0;
        end else if (mv) begin
            aceptar = 1'b1;
`ifdef RECHAZO_PICOS_EN
            begin
                int d;
                d = m - int'(exp_temp);
                if (d < 0) d = -d;
                if (hist.size() == 4 && d > UMBRAL) begin
                    if (consec < 3) begin
                        aceptar = 1'b0;
                        consec++;
                        if (exp_picos < 255) exp_picos++;
                    end else begin
                        consec = 0;
                    end
                end else begin
                    consec = 0;
                end
            end
`endif
            if (aceptar) begin
                hist.push_back(m);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hist.size() == 4) begin
                    s = 0;
                    foreach (hist[k]) s += hist[k];
                    exp_temp   = 11'(media_piso(s));
                    exp_valida = 1'b1;
                end
            end
        end
        muestra_valida = 1'b0;
        limpiar        = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        for (int i = 0; i < 3; i++) ciclo(1'b1, 1'b0, 300 + i);
        modelo_reset();
        total++; if (temp_filtrada !== 11'sd0) begin bad++; $display("FAIL reset temp: got %0d want 0", temp_filtrada); end
        total++; if (temp_valida !== 1'b0) begin bad++; $display("FAIL reset valida: got %b want 0", temp_valida); end
        total++; if (sensor_falla !== 1'b0) begin bad++; $display("FAIL reset falla: got %b want 0", sensor_falla); end
        total++; if (picos_rechazados !== 8'd0) begin bad++; $display("FAIL reset picos: got %0d want 0", picos_rechazados); end
        @(negedge clk);
        arst_n = 1'b1;
        ciclo(1'b0, 1'b0, 0);
        total++; if (temp_valida !== 1'b0) begin bad++; $display("FAIL post-reset valida: got %b want 0", temp_valida); end
    endtask

    task automatic test_llenado();
        int v[4] = '{100, 104, 108, 112};
        for (int k = 0; k < 4; k++) begin
            ciclo(1'b1, 1'b0, v[k]);
            if (k < 3) begin
                total++; if (temp_valida !== 1'b0) begin bad++; $display("FAIL llenado valida[%0d]: got %b want 0", k, temp_valida); end
            end
        end
        total++; if (temp_valida !== 1'b1) begin bad++; $display("FAIL llenado valida 4th: got %b want 1", temp_valida); end
        total++; if (temp_filtrada !== 11'sd106) begin bad++; $display("FAIL llenado temp: got %0d want 106", temp_filtrada); end
        ciclo(1'b0, 1'b0, 0);
        total++; if (temp_valida !== 1'b0) begin bad++; $display("FAIL llenado pulse width: got %b want 0", temp_valida); end
        total++; if (temp_filtrada !== 11'sd106) begin bad++; $display("FAIL llenado hold: got %0d want 106", temp_filtrada); end
    endtask

    task automatic test_piso_negativo();
        int v[4] = '{-3, -4, -4, -4};
        ciclo(1'b0, 1'b1, 0);
        total++; if (temp_filtrada !== 11'sd106) begin bad++; $display("FAIL limpiar hold: got %0d want 106", temp_filtrada); end
        for (int k = 0; k < 4; k++) ciclo(1'b1, 1'b0, v[k]);
        total++; if (temp_filtrada !== -11'sd4) begin bad++; $display("FAIL piso temp: got %0d want -4", temp_filtrada); end
        total++; if (temp_valida !== 1'b1) begin bad++; $display("FAIL piso valida: got %b want 1", temp_valida); end
        ciclo(1'b0, 1'b1, 0);
        for (int k = 0; k < 4; k++) ciclo(1'b1, 1'b0, -1024);
        total++; if (temp_filtrada !== -11'sd1024) begin bad++; $display("FAIL minimo temp: got %0d want -1024", temp_filtrada); end
        total++; if (temp_filtrada !== exp_temp) begin bad++; $display("FAIL minimo model: got %0d want %0d", temp_filtrada, exp_temp); end
    endtask

    task automatic test_picos();
        ciclo(1'b0, 1'b1, 0);
        for (int k = 0; k < 4; k++) ciclo(1'b1, 1'b0, 200);
        total++; if (temp_filtrada !== 11'sd200) begin bad++; $display("FAIL picos base: got %0d want 200", temp_filtrada); end
        ciclo(1'b1, 1'b0, 300);
`ifdef RECHAZO_PICOS_EN
        total++; if (temp_filtrada !== 11'sd200) begin bad++; $display("FAIL pico rechazado temp: got %0d want 200", temp_filtrada); end
        total++; if (temp_valida !== 1'b0) begin bad++; $display("FAIL pico rechazado valida: got %b want 0", temp_valida); end
        total++; if (picos_rechazados !== 8'd1) begin bad++; $display("FAIL pico cuenta: got %0d want 1", picos_rechazados); end
`else
        total++; if (temp_filtrada !== 11'sd225) begin bad++; $display("FAIL sin rechazo temp: got %0d want 225", temp_filtrada); end
        total++; if (picos_rechazados !== 8'd0) begin bad++; $display("FAIL sin rechazo picos: got %0d want 0", picos_rechazados); end
`endif
        for (int k = 0; k < 3; k++) begin
            ciclo(1'b1, 1'b0, 300);
            total++; if (temp_valida !== exp_valida) begin bad++; $display("FAIL picos valida[%0d]: got %b want %b", k, temp_valida, exp_valida); end
        end
`ifdef RECHAZO_PICOS_EN
        total++; if (temp_filtrada !== 11'sd225) begin bad++; $display("FAIL pico aceptado temp: got %0d want 225", temp_filtrada); end
        total++; if (temp_valida !== 1'b1) begin bad++; $display("FAIL pico aceptado valida: got %b want 1", temp_valida); end
        // Drive far-off samples until the reject counter must have saturated.
        for (int k = 0; k < 400; k++) ciclo(1'b1, 1'b0, (exp_temp > 0) ? -1000 : 1000);
        total++; if (picos_rechazados !== 8'd255) begin bad++; $display("FAIL picos saturacion: got %0d want 255", picos_rechazados); end
`else
        total++; if (temp_filtrada !== 11'sd300) begin bad++; $display("FAIL sin rechazo final: got %0d want 300", temp_filtrada); end
`endif
        total++; if (picos_rechazados !== 8'(exp_picos)) begin bad++; $display("FAIL picos model: got %0d want %0d", picos_rechazados, exp_picos); end
    endtask

    task automatic test_simultaneo();
        ciclo(1'b0, 1'b1, 0);
        ciclo(1'b1, 1'b0, 10);
        ciclo(1'b1, 1'b0, 20);
        ciclo(1'b1, 1'b0, 30);
        ciclo(1'b1, 1'b0, 40);
        total++; if (temp_filtrada !== 11'sd25) begin bad++; $display("FAIL simult base: got %0d want 25", temp_filtrada); end
        ciclo(1'b1, 1'b1, 500);
        total++; if (temp_valida !== 1'b0) begin bad++; $display("FAIL simult valida: got %b want 0", temp_valida); end
        total++; if (temp_filtrada !== 11'sd25) begin bad++; $display("FAIL simult hold: got %0d want 25", temp_filtrada); end
        for (int k = 0; k < 3; k++) begin
            ciclo(1'b1, 1'b0, 60);
            total++; if (temp_valida !== 1'b0) begin bad++; $display("FAIL simult refill valida[%0d]: got %b want 0", k, temp_valida); end
        end
        ciclo(1'b1, 1'b0, 60);
        total++; if (temp_filtrada !== 11'sd60) begin bad++; $display("FAIL simult refill temp: got %0d want 60", temp_filtrada); end
        total++; if (temp_valida !== 1'b1) begin bad++; $display("FAIL simult refill valida: got %b want 1", temp_valida); end
    endtask

    task automatic test_reset_mid_fill();
        ciclo(1'b0, 1'b1, 0);
        ciclo(1'b1, 1'b0, 7);
        ciclo(1'b1, 1'b0, 9);
        #3;
        arst_n = 1'b0;
        #1;
        total++; if (temp_filtrada !== 11'sd0) begin bad++; $display("FAIL async temp: got %0d want 0", temp_filtrada); end
        total++; if (temp_valida !== 1'b0) begin bad++; $display("FAIL async valida: got %b want 0", temp_valida); end
        total++; if (sensor_falla !== 1'b0) begin bad++; $display("FAIL async falla: got %b want 0", sensor_falla); end
        total++; if (picos_rechazados !== 8'd0) begin bad++; $display("FAIL async picos: got %0d want 0", picos_rechazados); end
        ciclo(1'b1, 1'b0, 11);
        ciclo(1'b1, 1'b0, 13);
        modelo_reset();
        @(negedge clk);
        arst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            ciclo(1'b1, 1'b0, k);
            total++; if (temp_valida !== (k == 4)) begin bad++; $display("FAIL refill after reset valida[%0d]: got %b want %b", k, temp_valida, (k == 4)); end
        end
        total++; if (temp_filtrada !== 11'sd2) begin bad++; $display("FAIL refill after reset temp: got %0d want 2", temp_filtrada); end
    endtask

    task automatic test_aleatorio();
        int base;
        int m;
        base = int'($urandom_range(0, 1000)) - 500;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) m = int'($urandom_range(0, 2047)) - 1024;
            else m = base + int'($urandom_range(0, 160)) - 80;
            ciclo($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, m);
            total++;
            if (temp_filtrada !== exp_temp || temp_valida !== exp_valida ||
                sensor_falla !== exp_falla || picos_rechazados !== 8'(exp_picos)) begin
                bad++;
                $display("FAIL aleatorio[%0d]: got t=%0d v=%b f=%b p=%0d want t=%0d v=%b f=%b p=%0d",
                         k, temp_filtrada, temp_valida, sensor_falla, picos_rechazados,
                         exp_temp, exp_valida, exp_falla, exp_picos);
            end
        end
    endtask

    task automatic test_timeout();
        arst_n = 1'b0;
        #7;
        modelo_reset();
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 1; i <= TIMEOUT + 5; i++) begin
            ciclo(1'b0, (i % 100) == 50, 0);
            total++;
            if (sensor_falla !== (i >= TIMEOUT) || sensor_falla !== exp_falla) begin
                bad++;
                $display("FAIL timeout ciclo %0d: got %b want %b", i, sensor_falla, (i >= TIMEOUT));
            end
        end
        ciclo(1'b1, 1'b0, 5);
        total++; if (sensor_falla !== 1'b0) begin bad++; $display("FAIL timeout clear: got %b want 0", sensor_falla); end
        ciclo(1'b0, 1'b0, 0);
        total++; if (sensor_falla !== 1'b0) begin bad++; $display("FAIL timeout restart: got %b want 0", sensor_falla); end
    endtask

    initial begin
        modelo_reset();
        test_reset();
        test_llenado();
        test_piso_negativo();
        test_picos();
        test_simultaneo();
        test_reset_mid_fill();
        test_aleatorio();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filtro_temp.md
FILTRO_TEMP -- requirements
Module: filtro_temp

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 1000, giving the idle cycles without a sample before sensor fault.
REQ-002 SHALL have parameter UMBRAL_PICO, default 50, giving the max |sample - current average| accepted as non-spike.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-004 SHALL have port arst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-005 SHALL have port muestra, input, 11 signed, the raw sensor temperature sample.
REQ-006 SHALL have port muestra_valida, input, 1, a one-cycle strobe qualifying muestra.
REQ-007 SHALL have port limpiar, input, 1, a synchronous restart of averaging.
REQ-008 SHALL have port temp_filtrada, output, 11 signed, the registered average; feeds the monitor's temp_entrada.
REQ-009 SHALL have port temp_valida, output, 1, a one-cycle pulse when temp_filtrada updates.
REQ-010 SHALL have port sensor_falla, output, 1, a level meaning no sample for TIMEOUT_CICLOS cycles.
REQ-011 SHALL have port picos_rechazados, output, 8, a saturating count of rejected spikes.

Function
REQ-012 SHALL average the last 4 accepted samples.
- 13-bit signed sum.
- Result = sum arithmetic-shifted right by 2, i.e. floor toward negative infinity.
- No overflow is possible across the full 11-bit range.
REQ-013 SHALL use the FSM states LLENADO and OPERACION; reset and limpiar enter LLENADO.
REQ-014 SHALL, in LLENADO, store accepted samples, count them 0..3, and never pulse temp_valida.
REQ-015 SHALL, on the 4th accepted sample in LLENADO, go to OPERACION and drive average plus temp_valida on the next cycle.
REQ-016 SHALL, in OPERACION, on each accepted sample, replace the oldest window entry and update temp_filtrada plus pulse temp_valida exactly 1 cycle later.
REQ-017 SHALL hold temp_filtrada between updates.
REQ-018 SHALL give limpiar priority over a simultaneous muestra_valida: the sample is discarded, the window is cleared, the fill count goes to 0, and temp_filtrada is held.
REQ-019 SHALL reset the timeout counter on every muestra_valida, accepted or rejected.
- The counter saturates at TIMEOUT_CICLOS.
- sensor_falla asserts when the count reaches TIMEOUT_CICLOS.
- sensor_falla clears the cycle after the next muestra_valida.
REQ-020 SHALL NOT change timeout behaviour on limpiar.

Reset
REQ-021 SHALL, while arst_n=0, force the following immediately, independent of clk:
- temp_filtrada=0, temp_valida=0, sensor_falla=0, picos_rechazados=0.
- Window entries 0, fill count 0, timeout count 0, consecutive-reject count 0, state LLENADO.
REQ-022 SHALL ignore muestra_valida while arst_n=0 and resume at the first clk edge after release.

Configuration
REQ-023 SHALL, with RECHAZO_PICOS_EN defined, apply spike rejection in OPERACION:
- A sample with |muestra - temp_filtrada| > UMBRAL_PICO is rejected: no window update, no temp_valida, picos_rechazados +1 saturating at 255.
- The 4th consecutive out-of-threshold sample is accepted and clears the consecutive-reject count.
- Any in-threshold sample also clears the consecutive-reject count.
REQ-024 SHALL, without RECHAZO_PICOS_EN, accept every sample and tie picos_rechazados to 0, with ports unchanged.

Structure
REQ-025 SHALL place the following in package filtro_temp_pkg, shared with the monitor stage:
- N_VENTANA=4.
- typedef temp_t (11-bit signed), typedef suma_t (13-bit signed).
- enum estado_filtro_t {LLENADO, OPERACION}.
REQ-026 SHALL implement the timeout counter and sensor_falla in sub-module vigilante_sensor, instantiated once.

Verification
REQ-027 SHALL cover fill: samples 100,104,108,112 -> no temp_valida during first three; temp_filtrada=106 with temp_valida one cycle after the 4th.
REQ-028 SHALL cover negative floor: -3,-4,-4,-4 -> temp_filtrada=-4; then sample -1024 x4 -> -1024, no overflow.
REQ-029 SHALL cover spikes (macro on), with the window at 200:
- One sample 300 -> rejected, output stays 200, picos_rechazados=1.
- Then 300 three more times -> the 4th is accepted, output 225.
REQ-030 SHALL cover timeout: with TIMEOUT_CICLOS=1000 and no muestra_valida, sensor_falla rises at cycle 1000; one sample clears it the next cycle.
REQ-031 SHALL cover simultaneous events and reset:
- limpiar together with muestra_valida in OPERACION -> sample dropped, LLENADO, output held.
- arst_n pulsed mid-fill -> all outputs 0 asynchronously.
